// File: rtl/sccb_pkg.sv
// Shared types and constants for the SCCB responder and its line synchronizer.
package sccb_pkg;

   typedef enum logic [3:0] {
      S_IDLE,
      S_ID,
      S_ID_ACK,
      S_SUB,
      S_SUB_ACK,
      S_WDATA,
      S_WDATA_ACK,
      S_RDATA,
      S_RNA,
      S_IGNORE
   } sccb_rsp_state_t;

   localparam logic [7:0] DEV_ID_DEFAULT      = 8'h42;
   localparam int         BITS_PER_PHASE      = 8;
   localparam int         SYNC_STAGES_DEFAULT = 2;

   // States in which a START/STOP that lands between bits is a framing error
   function automatic logic in_byte_state(input sccb_rsp_state_t s);
      return (s == S_ID) || (s == S_SUB) || (s == S_WDATA) || (s == S_RDATA);
   endfunction

endpackage

// File: rtl/sccb_line_sync.sv
// Synchronizes SIO_C/SIO_D into CLK_25M and derives clock edges plus START/STOP.
module sccb_line_sync
   import sccb_pkg::*;
#(
   parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_sio_c,
   input  logic i_sio_d,
   output logic o_sc,
   output logic o_sd,
   output logic o_sc_rise,
   output logic o_sc_fall,
   output logic o_start,
   output logic o_stop
);

   logic [SYNC_STAGES-1:0] r_sc_sync;
   logic [SYNC_STAGES-1:0] r_sd_sync;
   logic                   r_sc_prev;
   logic                   r_sd_prev;
   logic                   w_sc;
   logic                   w_sd;

   // Reset to the idle-bus level so release of RST never looks like an edge
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_sc_sync <= '1;
         r_sd_sync <= '1;
         r_sc_prev <= 1'b1;
         r_sd_prev <= 1'b1;
      end else begin
         r_sc_sync <= {r_sc_sync[SYNC_STAGES-2:0], i_sio_c};
         r_sd_sync <= {r_sd_sync[SYNC_STAGES-2:0], i_sio_d};
         r_sc_prev <= w_sc;
         r_sd_prev <= w_sd;
      end
   end

   assign w_sc      = r_sc_sync[SYNC_STAGES-1];
   assign w_sd      = r_sd_sync[SYNC_STAGES-1];
   assign o_sc      = w_sc;
   assign o_sd      = w_sd;
   assign o_sc_rise = w_sc & ~r_sc_prev;
   assign o_sc_fall = ~w_sc & r_sc_prev;
   assign o_start   = w_sc & r_sc_prev & r_sd_prev & ~w_sd;
   assign o_stop    = w_sc & r_sc_prev & ~r_sd_prev & w_sd;

endmodule

// File: rtl/sccb_responder.sv
// SCCB target for OV7670-style config traffic, backed by a 256x8 register model.
// state       | meaning
// IDLE        | bus free, waiting for START
// ID          | shifting in the device ID byte
// ID_ACK      | ACKing the ID (OE from bit-8 fall to 9th-clock fall)
// SUB         | shifting in the sub-address into the pointer
// SUB_ACK     | ACKing the sub-address
// WDATA       | shifting in the write data byte
// WDATA_ACK   | ACKing the data byte
// RDATA       | driving regfile[ptr] MSB first
// RNA         | master's NA/ACK bit, line released
// IGNORE      | not ours or done; wait for STOP/START
module sccb_responder
   import sccb_pkg::*;
#(
   parameter logic [7:0] DEV_ID      = DEV_ID_DEFAULT,
   parameter int         SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
   input  logic       CLK_25M,
   input  logic       RST,
   input  logic       SIO_C,
   input  logic       SIO_D_IN,
   output logic       SIO_D_OE,
   output logic       WR_STB,
   output logic [7:0] WR_ADDR,
   output logic [7:0] WR_DATA,
   output logic       BUSY,
   output logic       ERR
);

   sccb_rsp_state_t r_state, w_state_nxt;
   logic [2:0]      r_cnt;
   logic            r_pend;
   logic [7:0]      r_shift;
   logic [7:0]      r_ptr;
   logic [7:0]      r_rd_shift;
   logic            r_rw;
   logic [7:0]      r_regs [256];
   logic            r_oe, r_busy, r_err, r_wr_stb;
   logic [7:0]      r_wr_addr, r_wr_data;
   logic            w_oe_nxt, w_busy_nxt, w_err_nxt, w_wr_stb_nxt;
   logic            w_sc, w_sd, w_sc_rise, w_sc_fall, w_start, w_stop;
   logic [7:0]      w_byte;
   logic            w_last_bit, w_ack_done, w_id_match, w_mid_byte;

   sccb_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .i_clk     (CLK_25M),
      .i_rst     (RST),
      .i_sio_c   (SIO_C),
      .i_sio_d   (SIO_D_IN),
      .o_sc      (w_sc),
      .o_sd      (w_sd),
      .o_sc_rise (w_sc_rise),
      .o_sc_fall (w_sc_fall),
      .o_start   (w_start),
      .o_stop    (w_stop)
   );

   assign w_byte     = {r_shift[6:0], w_sd};
   assign w_last_bit = w_sc_rise && (r_cnt == 3'(BITS_PER_PHASE - 1));
   assign w_ack_done = w_sc_fall && (r_cnt == 3'd1);
   assign w_id_match = (w_byte[7:1] == DEV_ID[7:1]);
   // The SIO_C rise that precedes a normal START/STOP is not a completed bit
   assign w_mid_byte = (r_cnt != 3'd0) && !((r_cnt == 3'd1) && r_pend);

   always_ff @(posedge CLK_25M or posedge RST) begin
      if (RST) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (w_start) begin
         w_state_nxt = S_ID;
      end else if (w_stop) begin
         w_state_nxt = S_IDLE;
      end else begin
         case (r_state)
            S_ID:        if (w_last_bit) w_state_nxt = w_id_match ? S_ID_ACK : S_IGNORE;
            S_ID_ACK:    if (w_ack_done) w_state_nxt = r_rw ? S_RDATA : S_SUB;
            S_SUB:       if (w_last_bit) w_state_nxt = S_SUB_ACK;
            S_SUB_ACK:   if (w_ack_done) w_state_nxt = S_WDATA;
            S_WDATA:     if (w_last_bit) w_state_nxt = S_WDATA_ACK;
            S_WDATA_ACK: if (w_ack_done) w_state_nxt = S_IGNORE;
            S_RDATA:     if (w_last_bit) w_state_nxt = S_RNA;
            S_RNA:       if (w_sc_rise)  w_state_nxt = S_IGNORE;
            default:     w_state_nxt = r_state;
         endcase
      end
   end

   always_comb begin
      w_oe_nxt     = r_oe;
      w_busy_nxt   = r_busy;
      w_err_nxt    = 1'b0;
      w_wr_stb_nxt = 1'b0;
      if (w_start || w_stop) begin
         w_oe_nxt  = 1'b0;
         w_err_nxt = in_byte_state(r_state) && w_mid_byte;
         if (w_stop) w_busy_nxt = 1'b0;
      end else begin
         case (r_state)
            S_ID: if (w_last_bit) begin
               w_busy_nxt = w_id_match;
               w_err_nxt  = !w_id_match;
            end
            S_ID_ACK: if (w_sc_fall) begin
               if (r_cnt == 3'd0)   w_oe_nxt = 1'b1;
               else if (w_ack_done) w_oe_nxt = r_rw ? ~r_regs[r_ptr][7] : 1'b0;
            end
            S_SUB_ACK, S_WDATA_ACK: if (w_sc_fall) begin
               if (r_cnt == 3'd0)   w_oe_nxt = 1'b1;
               else if (w_ack_done) w_oe_nxt = 1'b0;
            end
            S_WDATA: if (w_last_bit) w_wr_stb_nxt = 1'b1;
            S_RDATA: if (w_sc_fall) w_oe_nxt = ~r_rd_shift[6];
            S_RNA:   if (!w_sc) w_oe_nxt = 1'b0;
            default: w_oe_nxt = r_oe;
         endcase
      end
   end

   always_ff @(posedge CLK_25M or posedge RST) begin
      if (RST) begin
         r_cnt      <= '0;
         r_pend     <= 1'b0;
         r_shift    <= '0;
         r_ptr      <= '0;
         r_rd_shift <= '0;
         r_rw       <= 1'b0;
         r_oe       <= 1'b0;
         r_busy     <= 1'b0;
         r_err      <= 1'b0;
         r_wr_stb   <= 1'b0;
         r_wr_addr  <= '0;
         r_wr_data  <= '0;
         for (int i = 0; i < 256; i++) r_regs[i] <= '0;
      end else begin
         r_oe     <= w_oe_nxt;
         r_busy   <= w_busy_nxt;
         r_err    <= w_err_nxt;
         r_wr_stb <= w_wr_stb_nxt;
         if (w_start || w_stop) begin
            r_cnt  <= '0;
            r_pend <= 1'b0;
         end else begin
            case (r_state)
               S_ID, S_SUB, S_WDATA, S_RDATA: begin
                  if (w_sc_rise) begin
                     r_shift <= w_byte;
                     r_cnt   <= r_cnt + 3'd1;
                     r_pend  <= 1'b1;
                  end else if (w_sc_fall) begin
                     r_pend  <= 1'b0;
                  end
               end
               S_ID_ACK, S_SUB_ACK, S_WDATA_ACK: begin
                  r_pend <= 1'b0;
                  if (w_sc_rise)       r_cnt <= r_cnt + 3'd1;
                  else if (w_ack_done) r_cnt <= '0;
               end
               default: r_pend <= 1'b0;
            endcase
            if (r_state == S_ID && w_last_bit)  r_rw  <= w_sd;
            if (r_state == S_SUB && w_last_bit) r_ptr <= w_byte;
            if (r_state == S_WDATA && w_last_bit) begin
               r_regs[r_ptr] <= w_byte;
               r_wr_addr     <= r_ptr;
               r_wr_data     <= w_byte;
            end
            if (r_state == S_ID_ACK && w_ack_done && r_rw)
               r_rd_shift <= r_regs[r_ptr];
            else if (r_state == S_RDATA && w_sc_fall)
               r_rd_shift <= {r_rd_shift[6:0], 1'b0};
         end
      end
   end

   assign SIO_D_OE = r_oe;
   assign WR_STB   = r_wr_stb;
   assign WR_ADDR  = r_wr_addr;
   assign WR_DATA  = r_wr_data;
   assign BUSY     = r_busy;
   assign ERR      = r_err;

endmodule

// File: tb/tb_sccb_responder.sv
// Directed bench for sccb_responder: table of write/read transactions plus corner sequences.
module tb_sccb_responder;

   localparam int HALF = 10;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       sio_c = 1'b1;
   logic       sd_m = 1'b1;
   logic       sio_d;
   logic       oe, wr_stb, busy, err;
   logic [7:0] wr_addr, wr_data;

   assign sio_d = sd_m & ~oe;

   always #20 clk = ~clk;

   sccb_responder #(.DEV_ID(8'h42), .SYNC_STAGES(2)) dut (
      .CLK_25M  (clk),
      .RST      (rst),
      .SIO_C    (sio_c),
      .SIO_D_IN (sio_d),
      .SIO_D_OE (oe),
      .WR_STB   (wr_stb),
      .WR_ADDR  (wr_addr),
      .WR_DATA  (wr_data),
      .BUSY     (busy),
      .ERR      (err)
   );

   int         n_pass = 0;
   int         n_total = 0;
   int         stb_cnt = 0;
   int         err_cnt = 0;
   logic [7:0] last_addr = 8'h00;
   logic [7:0] last_data = 8'h00;

   always @(negedge clk) begin
      if (wr_stb) begin
         stb_cnt   <= stb_cnt + 1;
         last_addr <= wr_addr;
         last_data <= wr_data;
      end
      if (err) err_cnt <= err_cnt + 1;
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, got, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
   endtask

   task automatic start_c();
      sd_m = 1'b1; tick(HALF);
      sio_c = 1'b1; tick(HALF);
      sd_m = 1'b0; tick(HALF);
      sio_c = 1'b0; tick(HALF);
   endtask

   task automatic stop_c();
      sd_m = 1'b0; tick(HALF);
      sio_c = 1'b1; tick(HALF);
      sd_m = 1'b1; tick(HALF);
   endtask

   task automatic send_bits(input logic [7:0] b, input int n);
      for (int i = 7; i > 7 - n; i--) begin
         sd_m = b[i]; tick(HALF);
         sio_c = 1'b1; tick(HALF);
         sio_c = 1'b0;
      end
   endtask

   task automatic send_byte(input logic [7:0] b, output logic ack);
      send_bits(b, 8);
      tick(2);
      sd_m = 1'b1; tick(HALF - 2);
      sio_c = 1'b1; tick(HALF / 2);
      #1 ack = oe;
      tick(HALF / 2);
      sio_c = 1'b0;
   endtask

   task automatic read_byte(output logic [7:0] b, output logic na_oe);
      b = 8'h00;
      sd_m = 1'b1;
      for (int i = 7; i >= 0; i--) begin
         tick(HALF);
         sio_c = 1'b1; tick(HALF / 2);
         #1 b[i] = sio_d;
         tick(HALF / 2);
         sio_c = 1'b0;
      end
      tick(HALF);
      sio_c = 1'b1; tick(HALF / 2);
      #1 na_oe = oe;
      tick(HALF / 2);
      sio_c = 1'b0;
   endtask

   task automatic do_write(input logic [7:0] a, input logic [7:0] d);
      logic k0, k1, k2;
      int   s0;
      s0 = stb_cnt;
      start_c();
      send_byte(8'h42, k0);
      chk("wr_busy_on", busy, 1);
      send_byte(a, k1);
      send_byte(d, k2);
      tick(4);
      chk("wr_ack_id", k0, 1);
      chk("wr_ack_sub", k1, 1);
      chk("wr_ack_data", k2, 1);
      chk("wr_stb_count", stb_cnt - s0, 1);
      chk("wr_addr", last_addr, a);
      chk("wr_data", last_data, d);
      stop_c();
      chk("wr_busy_off", busy, 0);
   endtask

   task automatic do_read(input logic [7:0] a, input logic [7:0] exp);
      logic       k0, k1, k2, na_oe;
      logic [7:0] b;
      int         s0;
      start_c();
      send_byte(8'h42, k0);
      send_byte(a, k1);
      stop_c();
      s0 = stb_cnt;
      start_c();
      send_byte(8'h43, k2);
      read_byte(b, na_oe);
      stop_c();
      chk("rd_ack_set_ptr", {k0, k1}, 2'b11);
      chk("rd_ack_id", k2, 1);
      chk("rd_data", b, exp);
      chk("rd_na_released", na_oe, 0);
      chk("rd_no_stb", stb_cnt - s0, 0);
   endtask

   typedef struct {
      logic       is_read;
      logic [7:0] addr;
      logic [7:0] data;
   } vec_t;

   vec_t vecs[9];

   initial begin
      #10_000_000;
      $display("FAIL watchdog: simulation did not complete, %0d/%0d so far", n_pass, n_total);
      $fatal(1);
   end

   initial begin
      logic       k0, k1, k2, na_oe;
      logic [7:0] b;
      int         e0, s0;

      vecs[0] = '{1'b0, 8'h12, 8'h04};
      vecs[1] = '{1'b0, 8'h40, 8'hD0};
      vecs[2] = '{1'b0, 8'hFF, 8'hA5};
      vecs[3] = '{1'b0, 8'h00, 8'h3C};
      vecs[4] = '{1'b1, 8'h40, 8'hD0};
      vecs[5] = '{1'b1, 8'h12, 8'h04};
      vecs[6] = '{1'b1, 8'hFF, 8'hA5};
      vecs[7] = '{1'b1, 8'h00, 8'h3C};
      vecs[8] = '{1'b1, 8'h55, 8'h00};

      tick(5);
      #1;
      chk("rst_oe", oe, 0);
      chk("rst_wr_stb", wr_stb, 0);
      chk("rst_wr_addr", wr_addr, 0);
      chk("rst_wr_data", wr_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", err, 0);
      @(negedge clk) rst = 1'b0;
      tick(10);

      for (int i = 0; i < 9; i++) begin
         if (vecs[i].is_read) do_read(vecs[i].addr, vecs[i].data);
         else                 do_write(vecs[i].addr, vecs[i].data);
      end
      chk("no_err_in_table", err_cnt, 0);

      // Foreign ID: no ACK, single ERR, BUSY stays low
      e0 = err_cnt; s0 = stb_cnt;
      start_c();
      send_byte(8'h60, k0);
      chk("bad_id_busy", busy, 0);
      send_byte(8'h12, k1);
      send_byte(8'h34, k2);
      stop_c();
      chk("bad_id_acks", {k0, k1, k2}, 3'b000);
      chk("bad_id_err", err_cnt - e0, 1);
      chk("bad_id_no_stb", stb_cnt - s0, 0);

      // STOP after four data bits aborts the write
      e0 = err_cnt; s0 = stb_cnt;
      start_c();
      send_byte(8'h42, k0);
      send_byte(8'h12, k1);
      send_bits(8'hFF, 4);
      stop_c();
      tick(4);
      chk("abort_acks", {k0, k1}, 2'b11);
      chk("abort_err", err_cnt - e0, 1);
      chk("abort_no_stb", stb_cnt - s0, 0);
      chk("abort_busy", busy, 0);
      start_c();
      send_byte(8'h43, k2);
      read_byte(b, na_oe);
      stop_c();
      chk("abort_reg_kept", b, 8'h04);

      // Repeated START between sub-address and read ID
      e0 = err_cnt;
      start_c();
      send_byte(8'h42, k0);
      send_byte(8'h20, k1);
      start_c();
      send_byte(8'h43, k2);
      read_byte(b, na_oe);
      stop_c();
      chk("rstart_acks", {k0, k1, k2}, 3'b111);
      chk("rstart_data", b, 8'h00);
      chk("rstart_no_err", err_cnt - e0, 0);

      // Async reset while the responder is pulling SIO_D low in a read
      start_c();
      send_byte(8'h43, k0);
      tick(5);
      #1;
      chk("mid_read_oe", oe, 1);
      chk("mid_read_busy", busy, 1);
      #5 rst = 1'b1;
      #1;
      chk("async_rst_oe", oe, 0);
      chk("async_rst_busy", busy, 0);
      sd_m = 1'b1;
      sio_c = 1'b1;
      tick(4);
      @(negedge clk) rst = 1'b0;
      tick(HALF);
      start_c();
      send_byte(8'h43, k1);
      read_byte(b, na_oe);
      stop_c();
      chk("post_rst_ack", k1, 1);
      chk("post_rst_data", b, 8'h00);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
